// File: rtl/alu_operand_result_stage.sv
// Operand/result staging around the Mini SRC ALU units: holds Y, B and opcode, waits
// an op-dependent settle time, then captures the 64-bit result into ZHigh/ZLow.
// Define ALU_FLAGS_EN to add the registered z_zero/z_neg result flags.
module alu_operand_result_stage #(
    parameter int SETTLE_CYCLES = 1,
    parameter int MULDIV_CYCLES = 8
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] bus_in,
    input  logic        y_in,
    input  logic        start,
    input  logic [3:0]  op,
    output logic [31:0] operand_a,
    output logic [31:0] operand_b,
    output logic [3:0]  opcode,
    input  logic [31:0] alu_lo,
    input  logic [31:0] alu_hi,
    input  logic        zhigh_out,
    input  logic        zlow_out,
    output logic [31:0] bus_out,
    output logic        busy,
    output logic        done,
    output logic        illegal_op
`ifdef ALU_FLAGS_EN
    ,
    output logic        z_zero,
    output logic        z_neg
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, CAPTURE} state_t;

    localparam logic [3:0] OP_SHR = 4'd4;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_DIV = 4'd10;
    localparam logic [3:0] OP_NOT = 4'd12;
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] MULDIV_LOAD = 8'(MULDIV_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic [31:0] y_reg;
    logic [31:0] b_reg;
    logic [31:0] zhigh;
    logic [31:0] zlow;
    logic [7:0]  count;
    logic        legal_start;
    logic        new_is_muldiv;
    logic        cur_is_muldiv;
    logic        cur_is_shift;

    assign legal_start   = start && (op <= OP_NOT);
    assign new_is_muldiv = (op == OP_MUL) || (op == OP_DIV);
    assign cur_is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign cur_is_shift  = (opcode >= OP_SHR) && (opcode <= OP_ROL);

    assign operand_a = y_reg;
    assign operand_b = cur_is_shift ? {27'b0, b_reg[4:0]} : b_reg;
    assign busy      = (state == EXEC) || (state == CAPTURE);

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (legal_start) next_state = EXEC;
            EXEC:    if (count == 8'd0) next_state = CAPTURE;
            CAPTURE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // done is registered alongside Z so the pulse lines up with the new Z value.
    always_ff @(posedge clock) begin
        if (clear) begin
            y_reg      <= '0;
            b_reg      <= '0;
            opcode     <= '0;
            zhigh      <= '0;
            zlow       <= '0;
            count      <= '0;
            done       <= 1'b0;
            illegal_op <= 1'b0;
`ifdef ALU_FLAGS_EN
            z_zero     <= 1'b0;
            z_neg      <= 1'b0;
`endif
        end else begin
            done <= (state == CAPTURE);
            if (y_in) y_reg <= bus_in;
            case (state)
                IDLE: begin
                    if (legal_start) begin
                        b_reg  <= bus_in;
                        opcode <= op;
                        count  <= new_is_muldiv ? MULDIV_LOAD : SETTLE_LOAD;
                    end else if (start) begin
                        illegal_op <= 1'b1;
                    end
                end
                EXEC: begin
                    if (count != 8'd0) count <= count - 8'd1;
                end
                CAPTURE: begin
                    zlow  <= alu_lo;
                    zhigh <= cur_is_muldiv ? alu_hi : 32'd0;
`ifdef ALU_FLAGS_EN
                    z_zero <= (alu_lo == 32'd0) && (cur_is_muldiv ? (alu_hi == 32'd0) : 1'b1);
                    z_neg  <= (opcode == OP_MUL) ? alu_hi[31] : alu_lo[31];
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus_out = '0;
        if (zlow_out) begin
            bus_out = zlow;
        end else if (zhigh_out) begin
            bus_out = zhigh;
        end
    end

endmodule

// File: tb/tb_alu_operand_result_stage.sv
// Self-checking bench for alu_operand_result_stage: a behavioural ALU stands in for the
// units, and expected Z values come from the op rules applied to the bench's own Y/B.
module tb_alu_operand_result_stage;

    localparam int SETTLE = 1;
    localparam int MULDIV = 8;

    logic        clock;
    logic        clear;
    logic [31:0] bus_in;
    logic        y_in;
    logic        start;
    logic [3:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  opcode;
    logic [31:0] alu_lo;
    logic [31:0] alu_hi;
    logic        zhigh_out;
    logic        zlow_out;
    logic [31:0] bus_out;
    logic        busy;
    logic        done;
    logic        illegal_op;
`ifdef ALU_FLAGS_EN
    logic        z_zero;
    logic        z_neg;
`endif

    int total = 0;
    int bad   = 0;

    alu_operand_result_stage #(.SETTLE_CYCLES(SETTLE), .MULDIV_CYCLES(MULDIV)) dut (
        .clock(clock), .clear(clear), .bus_in(bus_in), .y_in(y_in), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .opcode(opcode),
        .alu_lo(alu_lo), .alu_hi(alu_hi), .zhigh_out(zhigh_out), .zlow_out(zlow_out),
        .bus_out(bus_out), .busy(busy), .done(done), .illegal_op(illegal_op)
`ifdef ALU_FLAGS_EN
        , .z_zero(z_zero), .z_neg(z_neg)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Raw ALU behaviour; the high word carries junk for ops that do not define it.
    function automatic logic [63:0] alu_func(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        r = {32'hDEADBEEF, 32'h0};
        case (f)
            4'd0:  r[31:0] = a + b;
            4'd1:  r[31:0] = a - b;
            4'd2:  r[31:0] = a & b;
            4'd3:  r[31:0] = a | b;
            4'd4:  r[31:0] = a >> b;
            4'd5:  r[31:0] = 32'($signed(a) >>> b);
            4'd6:  r[31:0] = a << b;
            4'd7:  r[31:0] = (a >> b) | (a << (32'd32 - b));
            4'd8:  r[31:0] = (a << b) | (a >> (32'd32 - b));
            4'd9:  r = {32'd0, a} * {32'd0, b};
            4'd10: r = (b != 0) ? {a % b, a / b} : {a, 32'hFFFFFFFF};
            4'd11: r[31:0] = 32'd0 - b;
            4'd12: r[31:0] = ~b;
            default: r[31:0] = 32'd0;
        endcase
        return r;
    endfunction

    // Expected {ZHigh, ZLow} from the op rules: shift amounts are taken mod 32 and only
    // MUL/DIV keep a high word.
    function automatic logic [63:0] expect_z(input logic [3:0] f, input logic [31:0] y, input logic [31:0] b);
        logic [63:0] r;
        logic [31:0] bb;
        bb = (f >= 4 && f <= 8) ? (b % 32) : b;
        r = alu_func(f, y, bb);
        if (!(f == 4'd9 || f == 4'd10)) r[63:32] = 32'd0;
        return r;
    endfunction

    always_comb {alu_hi, alu_lo} = alu_func(opcode, operand_a, operand_b);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_y(input logic [31:0] v);
        y_in = 1'b1; bus_in = v;
        tick();
        y_in = 1'b0;
    endtask

    task automatic issue(input logic [3:0] f, input logic [31:0] v);
        start = 1'b1; op = f; bus_in = v;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output int busy_cycles, output bit timeout);
        cycles = 0; busy_cycles = 0; timeout = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
            cycles++;
            if (busy) busy_cycles++;
            if (done) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic read_z(output logic [31:0] hi, output logic [31:0] lo);
        zlow_out = 1'b1; zhigh_out = 1'b0; #1 lo = bus_out;
        zlow_out = 1'b0; zhigh_out = 1'b1; #1 hi = bus_out;
        zhigh_out = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] hi, lo;
        clear = 1'b1;
        tick(); tick();
        clear = 1'b0;
        read_z(hi, lo);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0h want=0", done); end
        total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%0h want=0", illegal_op); end
        total++; if (operand_a !== 32'd0) begin bad++; $display("FAIL reset_y got=%0h want=0", operand_a); end
        total++; if (operand_b !== 32'd0) begin bad++; $display("FAIL reset_b got=%0h want=0", operand_b); end
        total++; if (opcode !== 4'd0) begin bad++; $display("FAIL reset_opcode got=%0h want=0", opcode); end
        total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL reset_z got=%0h want=0", {hi, lo}); end
        total++; if (bus_out !== 32'd0) begin bad++; $display("FAIL reset_bus_out got=%0h want=0", bus_out); end
`ifdef ALU_FLAGS_EN
        total++; if ({z_zero, z_neg} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%0b want=00", {z_zero, z_neg}); end
`endif
    endtask

    task automatic test_rol();
        int c, bc; bit to;
        logic [31:0] hi, lo;
        load_y(32'h80000001);
        issue(4'd8, 32'h00000021);
        total++; if (operand_b !== 32'h1) begin bad++; $display("FAIL rol_operand_b got=%0h want=1", operand_b); end
        total++; if (opcode !== 4'd8) begin bad++; $display("FAIL rol_opcode got=%0h want=8", opcode); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rol_busy got=%0h want=1", busy); end
        wait_done(c, bc, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL rol_timeout got=%0d want=0", to); end
        total++; if (c !== SETTLE + 1) begin bad++; $display("FAIL rol_latency got=%0d want=%0d", c, SETTLE + 1); end
        read_z(hi, lo);
        total++; if (lo !== 32'h3) begin bad++; $display("FAIL rol_zlow got=%0h want=3", lo); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL rol_zhigh got=%0h want=0", hi); end
    endtask

    task automatic test_mul();
        int c, bc, busy_total; bit to;
        logic [31:0] hi, lo;
        load_y(32'hFFFFFFFF);
        issue(4'd9, 32'd2);
        busy_total = busy ? 1 : 0;
        start = 1'b1; op = 4'd0; bus_in = 32'h7;
        tick(); if (busy) busy_total++;
        tick(); if (busy) busy_total++;
        start = 1'b0;
        total++; if (opcode !== 4'd9) begin bad++; $display("FAIL mul_ignored_start_opcode got=%0h want=9", opcode); end
        total++; if (operand_b !== 32'd2) begin bad++; $display("FAIL mul_ignored_start_b got=%0h want=2", operand_b); end
        wait_done(c, bc, to);
        busy_total += bc;
        total++; if (to !== 1'b0) begin bad++; $display("FAIL mul_timeout got=%0d want=0", to); end
        total++; if (c + 2 !== MULDIV + 1) begin bad++; $display("FAIL mul_latency got=%0d want=%0d", c + 2, MULDIV + 1); end
        total++; if (busy_total !== MULDIV + 1) begin bad++; $display("FAIL mul_busy_cycles got=%0d want=%0d", busy_total, MULDIV + 1); end
        read_z(hi, lo);
        total++; if (hi !== 32'h1) begin bad++; $display("FAIL mul_zhigh got=%0h want=1", hi); end
        total++; if (lo !== 32'hFFFFFFFE) begin bad++; $display("FAIL mul_zlow got=%0h want=fffffffe", lo); end
    endtask

    task automatic test_illegal();
        int c, bc, done_seen; bit to;
        logic [31:0] hi, lo;
        issue(4'd14, 32'h123);
        total++; if (illegal_op !== 1'b1) begin bad++; $display("FAIL illegal_set got=%0h want=1", illegal_op); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL illegal_busy got=%0h want=0", busy); end
        total++; if (opcode !== 4'd9) begin bad++; $display("FAIL illegal_opcode got=%0h want=9", opcode); end
        done_seen = done ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) done_seen++;
        end
        total++; if (done_seen !== 0) begin bad++; $display("FAIL illegal_done got=%0d want=0", done_seen); end
        read_z(hi, lo);
        total++; if ({hi, lo} !== 64'h1_FFFFFFFE) begin bad++; $display("FAIL illegal_z got=%0h want=1fffffffe", {hi, lo}); end
        issue(4'd0, 32'd1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL illegal_then_add_busy got=%0h want=1", busy); end
        wait_done(c, bc, to);
        read_z(hi, lo);
        total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL illegal_then_add_z got=%0h want=0", {hi, lo}); end
        total++; if (illegal_op !== 1'b1) begin bad++; $display("FAIL illegal_sticky got=%0h want=1", illegal_op); end
    endtask

    task automatic test_clear_mid_exec();
        int c, bc, done_seen; bit to;
        logic [31:0] hi, lo;
        load_y(32'h1234);
        issue(4'd9, 32'd3);
        tick(); tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear_busy got=%0h want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL clear_done got=%0h want=0", done); end
        total++; if (operand_a !== 32'd0) begin bad++; $display("FAIL clear_y got=%0h want=0", operand_a); end
        total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL clear_illegal got=%0h want=0", illegal_op); end
        read_z(hi, lo);
        total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL clear_z got=%0h want=0", {hi, lo}); end
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy) done_seen++;
        end
        total++; if (done_seen !== 0) begin bad++; $display("FAIL clear_no_done got=%0d want=0", done_seen); end
        load_y(32'h10);
        issue(4'd0, 32'h22);
        wait_done(c, bc, to);
        total++; if (c !== SETTLE + 1) begin bad++; $display("FAIL clear_add_latency got=%0d want=%0d", c, SETTLE + 1); end
        read_z(hi, lo);
        total++; if (lo !== 32'h32) begin bad++; $display("FAIL clear_add_zlow got=%0h want=32", lo); end
    endtask

    task automatic test_simultaneous();
        int c, bc; bit to;
        y_in = 1'b1; start = 1'b1; op = 4'd0; bus_in = 32'h5;
        tick();
        y_in = 1'b0; start = 1'b0;
        total++; if (operand_a !== 32'h5) begin bad++; $display("FAIL simul_y got=%0h want=5", operand_a); end
        total++; if (operand_b !== 32'h5) begin bad++; $display("FAIL simul_b got=%0h want=5", operand_b); end
        wait_done(c, bc, to);
        zlow_out = 1'b1; zhigh_out = 1'b1;
        #1;
        total++; if (bus_out !== 32'hA) begin bad++; $display("FAIL simul_priority got=%0h want=a", bus_out); end
        zlow_out = 1'b0; zhigh_out = 1'b0;
        #1;
        total++; if (bus_out !== 32'h0) begin bad++; $display("FAIL simul_bus_idle got=%0h want=0", bus_out); end
    endtask

    task automatic test_back_to_back();
        int c, bc, want_lat; bit to;
        logic [31:0] y_model, b, hi, lo;
        logic [3:0] f;
        logic [63:0] want;
        y_model = $urandom;
        load_y(y_model);
        for (int n = 0; n < 30; n++) begin
            if (n % 3 == 2) begin
                y_model = $urandom;
                load_y(y_model);
            end
            f = 4'($urandom_range(0, 12));
            b = $urandom;
            if (f >= 4 && f <= 8 && $urandom_range(0, 2) == 0) b = 32'd32;
            if (f == 4'd10 && b == 0) b = 32'd7;
            want = expect_z(f, y_model, b);
            want_lat = ((f == 4'd9 || f == 4'd10) ? MULDIV : SETTLE) + 1;
            issue(f, b);
            wait_done(c, bc, to);
            read_z(hi, lo);
            total++; if (to !== 1'b0 || c !== want_lat) begin bad++; $display("FAIL b2b_latency op=%0d got=%0d want=%0d", f, c, want_lat); end
            total++; if ({hi, lo} !== want) begin bad++; $display("FAIL b2b_z op=%0d y=%0h b=%0h got=%0h want=%0h", f, y_model, b, {hi, lo}, want); end
        end
    endtask

`ifdef ALU_FLAGS_EN
    task automatic test_flags();
        int c, bc; bit to;
        load_y(32'h5);
        issue(4'd1, 32'h5);
        wait_done(c, bc, to);
        total++; if ({z_zero, z_neg} !== 2'b10) begin bad++; $display("FAIL flags_sub_zero got=%0b want=10", {z_zero, z_neg}); end
        issue(4'd11, 32'h1);
        wait_done(c, bc, to);
        total++; if ({z_zero, z_neg} !== 2'b01) begin bad++; $display("FAIL flags_neg got=%0b want=01", {z_zero, z_neg}); end
        tick(); tick();
        total++; if ({z_zero, z_neg} !== 2'b01) begin bad++; $display("FAIL flags_hold got=%0b want=01", {z_zero, z_neg}); end
    endtask
`endif

    initial begin
        clear = 1'b1; bus_in = '0; y_in = 1'b0; start = 1'b0; op = '0;
        zhigh_out = 1'b0; zlow_out = 1'b0;
        test_reset();
        test_rol();
        test_mul();
        test_illegal();
        test_clear_mid_exec();
        test_simultaneous();
        test_back_to_back();
`ifdef ALU_FLAGS_EN
        test_flags();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_result_stage.md
Name: alu_operand_result_stage

Overview:
- Sequential wrapper around the combinational ALU units (add/sub, logic, shift/rotate, mul/div) in the Mini SRC datapath.
- Upstream side: holds the Y operand, the B operand and the opcode, and presents them to the units. For shift/rotate ops it normalises B to a 5-bit amount.
- Downstream side: waits an op-dependent settle time, captures the 64-bit result into ZHigh/ZLow, and drives either half onto the bus on request.

Parameters:
- SETTLE_CYCLES, 1, cycles from issue to capture for single-cycle ops (1..15).
- MULDIV_CYCLES, 8, cycles from issue to capture for MUL/DIV (1..255).

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  synchronous active-high reset
- bus_in  in  32  datapath bus
- y_in  in  1  latch bus_in into Y (accepted any state)
- start  in  1  latch bus_in as B and op as opcode, begin execution (accepted in IDLE only)
- op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 MUL, 10 DIV, 11 NEG, 12 NOT; 13-15 illegal
- operand_a  out  32  Y register to ALU units
- operand_b  out  32  B operand to ALU units; for ops 4-8 this is {27'b0, B[4:0]}
- opcode  out  4  latched opcode to ALU result mux
- alu_lo  in  32  combinational result low word (all ops)
- alu_hi  in  32  high word (MUL product high, DIV remainder; ignored otherwise)
- zhigh_out  in  1  request ZHigh on bus_out
- zlow_out  in  1  request ZLow on bus_out
- bus_out  out  32  selected Z half, 0 when neither requested
- busy  out  1  high in EXEC and CAPTURE
- done  out  1  one-cycle pulse on the cycle Z updates
- illegal_op  out  1  sticky; set when start arrives with op 13-15

Behaviour:
- Reset values: all of the following are 0: Y, B, opcode, Z, busy, done, illegal_op, bus_out and the counter. State is IDLE.
- The FSM has three states: IDLE, EXEC and CAPTURE.
- IDLE, start=1, legal op:
  - latch B and opcode, load counter with (op in {9,10} ? MULDIV_CYCLES : SETTLE_CYCLES) - 1;
  - go to EXEC; busy rises the next cycle.
- IDLE, start=1, op 13-15:
  - set illegal_op; no state change; Z is untouched; done does not pulse.
- EXEC:
  - counter decrements each cycle; when the counter equals 0, go to CAPTURE;
  - start is ignored.
- CAPTURE:
  - ZLow <= alu_lo.
  - ZHigh <= alu_hi for MUL/DIV; ZHigh <= 0 for all other ops.
  - done pulses in this cycle; the next state is IDLE.
- Latency: start edge to done equals settle + 1 cycles. With SETTLE_CYCLES=1, done is asserted 2 cycles after start is sampled.
- Back-to-back: start is accepted in the IDLE cycle immediately after CAPTURE.
- y_in in any state updates Y next edge. It is the user's problem if Y changes mid-EXEC; operand_a follows Y immediately, and there is no shadow copy.
- y_in and start in the same cycle: Y and B both load from the same bus_in value.
- bus_out is registered-free combinational from Z:
  - zhigh_out selects ZHigh;
  - zlow_out selects ZLow;
  - both high gives ZLow (priority).
- Reading Z during CAPTURE returns the pre-update value.
- Shift amount normalisation: only B[4:0] passes to the units for ops 4-8. An amount of 32 therefore becomes 0, and the result equals operand A.
- clear mid-EXEC: returns to IDLE at the next edge with all registers zeroed and no done pulse. illegal_op is cleared only by clear.

Optional Feature:
- Macro ALU_FLAGS_EN.
- Defined: adds outputs z_zero (1) and z_neg (1).
  - Both are registered in CAPTURE: z_zero = (alu_lo == 0) && (MUL/DIV ? alu_hi == 0 : 1); z_neg = alu_lo[31] (MUL: alu_hi[31]).
  - Both reset to 0 and hold until the next CAPTURE.
- Undefined: the ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- ROL issue, defaults: y_in with bus 0x80000001, then start op=8 with bus 0x00000021. Required: operand_b=0x00000001, done 2 cycles after start, ZLow=0x00000003 (modelled rol), ZHigh=0, zlow_out gives bus_out=0x00000003.
- MUL latency, MULDIV_CYCLES=8: start op=9, model alu_hi=0x1, alu_lo=0xFFFFFFFE. Required: busy for 9 cycles, done exactly 9 cycles after start, ZHigh=0x1, ZLow=0xFFFFFFFE; start during busy is ignored.
- Illegal op: start op=14 in IDLE. Required: illegal_op=1 the next cycle, state stays IDLE, Z unchanged, no done; illegal_op stays set until clear.
- Clear mid-EXEC (MUL, 3 cycles in): clear=1. Required: next edge has busy=0, Z=0, Y=0, no done; a fresh ADD then completes normally.
- Simultaneous y_in+start, bus=0x5: Y=B=0x5; op=0 with model alu_lo=0xA gives ZLow=0xA; zhigh_out and zlow_out both high gives bus_out=ZLow.
- ALU_FLAGS_EN: SUB giving alu_lo=0 gives z_zero=1, z_neg=0; then NEG giving 0xFFFFFFFF gives z_zero=0, z_neg=1.
